palette_port_arbiter: RTL and testbench

//  Shares one combinational sprite palette (8-bit index -> 24-bit RGB) between N_REQ sprite

---
 rtl/palette_port_arbiter_pkg.sv | 14 +
 rtl/palette_port_arbiter_if.sv | 30 +++
 rtl/palette_port_arbiter_rr_arbiter.sv | 29 ++
 rtl/palette_port_arbiter.sv | 99 +++++++++
 tb/tb_palette_port_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/palette_port_arbiter_pkg.sv
// palette_pkg: shared types and constants for the sprite palette port arbiter.
//   pal_idx_t          8-bit palette index
//   rgb_t              24-bit RGB colour
//   TRANSP_RGB         key colour stored at the transparent palette slot
//   DEFAULT_TRANSP_IDX palette index treated as transparent by default
package palette_pkg;
   typedef logic [7:0]  pal_idx_t;
   typedef logic [23:0] rgb_t;
   localparam rgb_t     TRANSP_RGB         = 24'h800080;
   localparam pal_idx_t DEFAULT_TRANSP_IDX = 8'h00;
   function automatic logic is_transparent(input pal_idx_t idx, input pal_idx_t key);
      return idx == key;
   endfunction
endpackage

// File: rtl/palette_port_arbiter_if.sv
// palette_port_arbiter_if: request, palette and response signals of the palette port.
//   master: sprite engines / palette ROM / compositor side
//           drives req, req_index, pal_rgb, rsp_ready
//   slave : arbiter side
//           drives gnt, pal_index, rsp_valid, rsp_id, rsp_rgb, rsp_transparent
interface palette_port_arbiter_if
   import palette_pkg::*;
#(
   parameter int N_REQ = 4
) ();
   localparam int IW = $clog2(N_REQ);
   logic [N_REQ-1:0]   req;
   logic [N_REQ*8-1:0] req_index;
   logic [N_REQ-1:0]   gnt;
   pal_idx_t           pal_index;
   rgb_t               pal_rgb;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IW-1:0]      rsp_id;
   rgb_t               rsp_rgb;
   logic               rsp_transparent;
   modport master (
      output req, req_index, pal_rgb, rsp_ready,
      input  gnt, pal_index, rsp_valid, rsp_id, rsp_rgb, rsp_transparent
   );
   modport slave (
      input  req, req_index, pal_rgb, rsp_ready,
      output gnt, pal_index, rsp_valid, rsp_id, rsp_rgb, rsp_transparent
   );
endinterface

// File: rtl/palette_port_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester after ptr_i, wrapping N-1 -> 0.
//   req_i      request per requester
//   advance_i  grants are suppressed when low
//   ptr_i      last granted requester; tie to N-1 for fixed priority (0 highest)
//   gnt_o      one-hot grant, zero when nothing requests or advance_i is low
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic          advance_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);
   logic          found;
   logic [PW-1:0] j;
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      j     = '0;
      for (int k = 1; k <= N; k++) begin
         j = PW'((int'(ptr_i) + k) % N);
         if (advance_i && !found && req_i[j]) begin
            gnt_o[j] = 1'b1;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/palette_port_arbiter.sv
// palette_port_arbiter: shares one combinational palette between N_REQ sprite engines.
//   Clk    system clock, all state on rising edge
//   Reset  asynchronous active-high reset, flushes both pipeline stages
//   bus    slave modport: req/req_index/gnt accept side, pal_index/pal_rgb palette side,
//          rsp_valid/rsp_ready/rsp_id/rsp_rgb/rsp_transparent compositor side
// Pipeline: accept (T) -> S1 pal_index registered (T+1) -> S2 rsp_* registered (T+2).
module palette_port_arbiter
   import palette_pkg::*;
#(
   parameter int       N_REQ      = 4,
   parameter bit       FIXED_PRIO = 1'b0,
   parameter pal_idx_t TRANSP_IDX = DEFAULT_TRANSP_IDX
) (
   input logic                  Clk,
   input logic                  Reset,
   palette_port_arbiter_if.slave bus
);
   localparam int IW = $clog2(N_REQ);
   logic          adv1, adv2, accept;
   logic [N_REQ-1:0] gnt;
   logic [IW-1:0] gnt_id, ptr_q, ptr_d, s1_id_q, s1_id_d, rsp_id_q, rsp_id_d;
   pal_idx_t      sel_idx, pal_index_q, pal_index_d;
   rgb_t          rsp_rgb_q, rsp_rgb_d;
   logic          s1_valid_q, s1_valid_d, rsp_valid_q, rsp_valid_d, rsp_tr_q, rsp_tr_d;
   assign adv2   = !rsp_valid_q || bus.rsp_ready;
   assign adv1   = !s1_valid_q || adv2;
   assign accept = |gnt;
   // Gating with Reset keeps gnt low for the whole time reset is held.
   rr_arbiter #(.N(N_REQ)) u_arb (
      .req_i     (bus.req),
      .advance_i (adv1 && !Reset),
      .ptr_i     (FIXED_PRIO ? IW'(N_REQ - 1) : ptr_q),
      .gnt_o     (gnt)
   );
   always_comb begin
      gnt_id  = '0;
      sel_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gnt_id  = IW'(i);
            sel_idx = bus.req_index[8*i +: 8];
         end
      end
   end
   // pal_index and all rsp_* payload hold unless a new item enters their stage.
   always_comb begin
      ptr_d       = ptr_q;
      s1_valid_d  = s1_valid_q;
      s1_id_d     = s1_id_q;
      pal_index_d = pal_index_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_rgb_d   = rsp_rgb_q;
      rsp_tr_d    = rsp_tr_q;
      if (adv1) begin
         s1_valid_d = accept;
         if (accept) begin
            pal_index_d = sel_idx;
            s1_id_d     = gnt_id;
            ptr_d       = gnt_id;
         end
      end
      if (adv2) begin
         rsp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            rsp_id_d  = s1_id_q;
            rsp_rgb_d = bus.pal_rgb;
            rsp_tr_d  = is_transparent(pal_index_q, TRANSP_IDX);
         end
      end
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ptr_q       <= IW'(N_REQ - 1);
         s1_valid_q  <= 1'b0;
         s1_id_q     <= '0;
         pal_index_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_rgb_q   <= '0;
         rsp_tr_q    <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_id_q     <= s1_id_d;
         pal_index_q <= pal_index_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rgb_q   <= rsp_rgb_d;
         rsp_tr_q    <= rsp_tr_d;
      end
   end
   assign bus.gnt             = gnt;
   assign bus.pal_index       = pal_index_q;
   assign bus.rsp_valid       = rsp_valid_q;
   assign bus.rsp_id          = rsp_id_q;
   assign bus.rsp_rgb         = rsp_rgb_q;
   assign bus.rsp_transparent = rsp_tr_q;
endmodule

// File: tb/tb_palette_port_arbiter.sv
// tb_palette_port_arbiter: round-robin and fixed-priority instances against a transaction-level model.
module tb_palette_port_arbiter;
   import palette_pkg::*;
   typedef struct {
      int       id;
      logic [7:0] idx;
      int       t;
   } item_t;
   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_index = '0;
   logic        rsp_ready = 1'b1;
   int          n_chk = 0, n_fail = 0, cyc = 0;
   item_t       mq[2][$];
   int          mptr[2];
   logic [7:0]  mlast[2];
   logic [3:0]  eg[2];
   logic        vis[2];
   logic [3:0]  gnt_o[2];
   logic        rv_o[2], tr_o[2];
   logic [1:0]  id_o[2];
   logic [23:0] rgb_o[2];
   logic [7:0]  pi_o[2];
   always #5 Clk = ~Clk;
   function automatic logic [23:0] rom(input logic [7:0] idx);
      if (idx == 8'h00) return TRANSP_RGB;
      if (idx == 8'h11) return 24'hff0000;
      if (idx == 8'h0c) return 24'he69e8b;
      return {idx, idx ^ 8'ha5, ~idx};
   endfunction
   palette_port_arbiter_if #(.N_REQ(4)) bus_rr ();
   palette_port_arbiter_if #(.N_REQ(4)) bus_fp ();
   assign bus_rr.req       = req;
   assign bus_rr.req_index = req_index;
   assign bus_rr.rsp_ready = rsp_ready;
   assign bus_rr.pal_rgb   = rom(bus_rr.pal_index);
   assign bus_fp.req       = req;
   assign bus_fp.req_index = req_index;
   assign bus_fp.rsp_ready = rsp_ready;
   assign bus_fp.pal_rgb   = rom(bus_fp.pal_index);
   palette_port_arbiter #(.N_REQ(4), .FIXED_PRIO(1'b0)) dut_rr (.Clk(Clk), .Reset(Reset), .bus(bus_rr));
   palette_port_arbiter #(.N_REQ(4), .FIXED_PRIO(1'b1)) dut_fp (.Clk(Clk), .Reset(Reset), .bus(bus_fp));
   assign gnt_o[0] = bus_rr.gnt;       assign gnt_o[1] = bus_fp.gnt;
   assign rv_o[0]  = bus_rr.rsp_valid; assign rv_o[1]  = bus_fp.rsp_valid;
   assign tr_o[0]  = bus_rr.rsp_transparent; assign tr_o[1] = bus_fp.rsp_transparent;
   assign id_o[0]  = bus_rr.rsp_id;    assign id_o[1]  = bus_fp.rsp_id;
   assign rgb_o[0] = bus_rr.rsp_rgb;   assign rgb_o[1] = bus_fp.rsp_rgb;
   assign pi_o[0]  = bus_rr.pal_index; assign pi_o[1]  = bus_fp.pal_index;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
      end
   endtask
   // Two lookups can be in flight; a third is accepted only if the oldest leaves this cycle.
   function automatic logic [3:0] exp_gnt(input int d);
      int j;
      if (Reset || !(mq[d].size() < 2 || rsp_ready)) return 4'b0;
      for (int k = 1; k <= 4; k++) begin
         j = (d == 1) ? k - 1 : (mptr[d] + k) % 4;
         if (req[j]) return 4'(1 << j);
      end
      return 4'b0;
   endfunction
   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mq[d].delete();
         mptr[d]  = 3;
         mlast[d] = 8'h00;
      end
   endtask
   task automatic cycle();
      item_t it;
      @(negedge Clk);
      for (int d = 0; d < 2; d++) begin
         eg[d]  = exp_gnt(d);
         vis[d] = 1'b0;
         if (mq[d].size() > 0) vis[d] = (cyc - mq[d][0].t) >= 2;
         check($sformatf("gnt[%0d]", d), 32'(gnt_o[d]), 32'(eg[d]));
         check($sformatf("pal_index[%0d]", d), 32'(pi_o[d]), 32'(mlast[d]));
         check($sformatf("rsp_valid[%0d]", d), 32'(rv_o[d]), 32'(vis[d]));
         if (vis[d]) begin
            it = mq[d][0];
            check($sformatf("rsp_id[%0d]", d), 32'(id_o[d]), 32'(it.id));
            check($sformatf("rsp_rgb[%0d]", d), 32'(rgb_o[d]), 32'(rom(it.idx)));
            check($sformatf("rsp_transparent[%0d]", d), 32'(tr_o[d]), 32'(it.idx == 8'h00));
         end
      end
      @(posedge Clk);
      for (int d = 0; d < 2; d++) begin
         if (!Reset) begin
            if (vis[d] && rsp_ready) void'(mq[d].pop_front());
            for (int j = 0; j < 4; j++) begin
               if (eg[d][j]) begin
                  it.id  = j;
                  it.idx = req_index[8*j +: 8];
                  it.t   = cyc;
                  mq[d].push_back(it);
                  mlast[d] = it.idx;
                  mptr[d]  = j;
               end
            end
         end
      end
      cyc++;
      #1;
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask
   initial begin
      model_reset();
      #1 Reset = 1'b1;
      run(2);
      Reset = 1'b0;
      // single lookup with full latency
      req = 4'b0001; req_index = 32'h0000_0011;
      cycle();
      req = 4'b0000;
      run(3);
      // all requesting, round-robin rotation at full throughput
      req = 4'b1111; req_index = 32'h4433_2211;
      run(9);
      req = 4'b0000;
      run(3);
      // fixed priority starves requester 3
      req = 4'b1010;
      run(6);
      req = 4'b0000;
      run(3);
      // transparent key and an ordinary colour
      req = 4'b0001; req_index = 32'h0000_0000;
      cycle();
      req_index = 32'h0000_000c;
      cycle();
      req = 4'b0000;
      run(3);
      // back-pressure with two requesters
      req = 4'b0011; req_index = 32'h0000_0c00; rsp_ready = 1'b0;
      run(3);
      rsp_ready = 1'b1; req = 4'b0000;
      run(4);
      // reset while both stages are full
      req = 4'b0011; rsp_ready = 1'b0;
      run(3);
      Reset = 1'b1;
      #1;
      check("reset rsp_valid rr", 32'(rv_o[0]), 32'd0);
      check("reset rsp_valid fp", 32'(rv_o[1]), 32'd0);
      check("reset gnt rr", 32'(gnt_o[0]), 32'd0);
      check("reset gnt fp", 32'(gnt_o[1]), 32'd0);
      model_reset();
      cycle();
      Reset = 1'b0; rsp_ready = 1'b1; req = 4'b1111;
      run(5);
      // randomized traffic with random back-pressure
      for (int i = 0; i < 400; i++) begin
         req       = 4'($urandom);
         req_index = $urandom;
         if ($urandom_range(0, 3) == 0) req_index[8*$urandom_range(0, 3) +: 8] = 8'h00;
         rsp_ready = $urandom_range(0, 3) != 0;
         cycle();
      end
      req = 4'b0000; rsp_ready = 1'b1;
      run(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
